alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
- ID/EX pipeline register plus forwarding unit; sits directly upstream of the 16-bit ALU logic units (AND/OR/ADD, etc.).
- Captures decoded operands each cycle and resolves EX/MEM and MEM/WB data hazards.
- Drives the final ALU operands NewX/NewY together with the control fields that travel with them into EX.

Parameters:
- WIDTH, 16, datapath width of operands and results
- RADDR, 3, register-specifier width (8-entry register file, r0 hardwired zero)
- OPW, 3, ALU operation code width

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- id_valid  input  1  ID stage holds a real instruction
- id_rs_data  input  WIDTH  register-file read data, rs
- id_rt_data  input  WIDTH  register-file read data, rt
- id_imm  input  WIDTH  sign/zero-extended immediate
- id_rs  input  RADDR  rs specifier
- id_rt  input  RADDR  rt specifier
- id_rd  input  RADDR  destination specifier (already muxed rt/rd)
- id_alusrc  input  1  1 selects immediate for Y
- id_aluop  input  OPW  ALU operation
- id_regwrite  input  1  instruction writes a register
- stall  input  1  hold stage contents (load-use hazard)
- flush  input  1  insert bubble (branch taken)
- exmem_regwrite  input  1  EX/MEM writes a register
- exmem_rd  input  RADDR  EX/MEM destination
- exmem_result  input  WIDTH  EX/MEM ALU result
- memwb_regwrite  input  1  MEM/WB writes a register
- memwb_rd  input  RADDR  MEM/WB destination
- memwb_result  input  WIDTH  MEM/WB writeback data
- NewX  output  WIDTH  ALU operand X
- NewY  output  WIDTH  ALU operand Y
- ex_storedata  output  WIDTH  forwarded rt value (for stores)
- ex_aluop  output  OPW  registered ALU op
- ex_rd  output  RADDR  registered destination
- ex_regwrite  output  1  registered regwrite, gated by valid
- ex_valid  output  1  EX stage holds a real instruction
- fwd_x  output  2  X source select: 00 regfile, 10 EX/MEM, 01 MEM/WB
- fwd_y  output  2  rt source select, same encoding

Behaviour:
- Reset (rst_n low, asynchronous): all stage registers cleared to 0. Consequences: ex_valid=0, ex_regwrite=0, ex_aluop=0, ex_rd=0, fwd_x=fwd_y=00, NewX=NewY=ex_storedata=0. Reset asserted mid-operation discards the in-flight instruction immediately, with no waiting for a clock edge.
- Register update on posedge clk, priority flush > stall > load:
  - flush=1: bubble loaded. valid=0, regwrite=0, all data/specifier fields=0.
  - stall=1 (flush=0): every register holds its value.
  - otherwise: all id_* fields loaded. Registered regwrite = id_regwrite & id_valid.
- Latency: one cycle from ID inputs to EX outputs. Forwarding is combinational from registered specifiers and the current exmem_*/memwb_* inputs.
- Forwarding for source s (registered rs for X, registered rt for Y/store):
  - EX/MEM match: exmem_regwrite=1, exmem_rd==s and s!=0 -> select exmem_result, code 10.
  - Else MEM/WB match: memwb_regwrite=1, memwb_rd==s and s!=0 -> select memwb_result, code 01.
  - Else registered regfile data, code 00.
  - EX/MEM has priority when both match (newest value wins).
  - Specifier 0 never forwards; r0 data passes through as captured.
- Operand outputs:
  - NewX = forwarded rs.
  - ex_storedata = forwarded rt.
  - NewY = registered imm if registered alusrc=1, else forwarded rt. fwd_y still reports the rt decision when alusrc=1.
- Bubble/invalid: fwd_x/fwd_y still computed from the stored zero specifiers, so they read 00.
- Widths: all data paths WIDTH bits, no arithmetic, no truncation.
- During stall: forwarding is re-evaluated every cycle, so held operands pick up newly arriving MEM/WB results.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with ex_valid=1 -> ex_valid, ex_regwrite, NewX, NewY become 0 before the next clk edge.
- Plain load: id_rs_data=16'h00F0, id_rt_data=16'h0F0F, alusrc=0, no matches -> next cycle NewX=00F0, NewY=0F0F, fwd_x=fwd_y=00.
- Immediate: alusrc=1, id_imm=16'hFFFF, rt=3, exmem_rd=3, exmem_regwrite=1 -> NewY=FFFF, fwd_y=10, ex_storedata=exmem_result.
- Double hazard: rs=2, exmem_rd=2 (result 1234), memwb_rd=2 (result 5678), both regwrite=1 -> NewX=1234, fwd_x=10. Repeat with rs=0 -> fwd_x=00, NewX=captured data.
- Stall then flush: stall=1 for 2 cycles with new id_* values -> outputs unchanged. Assert stall=1 and flush=1 together -> ex_valid=0, ex_regwrite=0 next cycle.
- MEM/WB during stall: stall held, memwb_rd changes to match rs (result 00AA) -> NewX switches to 00AA the same cycle, fwd_x=01.

Source files
------------

// File: rtl/alu_operand_stage.sv
// -----------------------------------------------------------------------------
// alu_operand_stage
//   ID/EX pipeline register with the forwarding unit that feeds the 16-bit ALU.
//   Decoded operands are captured once per cycle. The final ALU operands
//   (NewX/NewY) and the store data are then resolved combinationally against
//   the EX/MEM and MEM/WB writeback paths.
//
// Ports
//   clk, rst_n              rising-edge clock, asynchronous active-low reset
//   id_valid                ID stage holds a real instruction
//   id_rs_data, id_rt_data  register-file read data for rs / rt
//   id_imm                  extended immediate
//   id_rs, id_rt, id_rd     source and destination specifiers
//   id_alusrc               1 selects the immediate for operand Y
//   id_aluop, id_regwrite   control fields that travel into EX
//   stall, flush            hold the stage / load a bubble (flush wins)
//   exmem_*, memwb_*        writeback candidates used for forwarding
//   NewX, NewY              ALU operands
//   ex_storedata            forwarded rt value, used by stores
//   ex_aluop, ex_rd         registered control fields
//   ex_regwrite, ex_valid   registered regwrite (gated by valid) and valid
//   fwd_x, fwd_y            source selects: 00 regfile, 10 EX/MEM, 01 MEM/WB
// -----------------------------------------------------------------------------
module alu_operand_stage #(
   parameter int WIDTH = 16,
   parameter int RADDR = 3,
   parameter int OPW   = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [WIDTH-1:0] id_rs_data,
   input  logic [WIDTH-1:0] id_rt_data,
   input  logic [WIDTH-1:0] id_imm,
   input  logic [RADDR-1:0] id_rs,
   input  logic [RADDR-1:0] id_rt,
   input  logic [RADDR-1:0] id_rd,
   input  logic             id_alusrc,
   input  logic [OPW-1:0]   id_aluop,
   input  logic             id_regwrite,
   input  logic             stall,
   input  logic             flush,
   input  logic             exmem_regwrite,
   input  logic [RADDR-1:0] exmem_rd,
   input  logic [WIDTH-1:0] exmem_result,
   input  logic             memwb_regwrite,
   input  logic [RADDR-1:0] memwb_rd,
   input  logic [WIDTH-1:0] memwb_result,
   output logic [WIDTH-1:0] NewX,
   output logic [WIDTH-1:0] NewY,
   output logic [WIDTH-1:0] ex_storedata,
   output logic [OPW-1:0]   ex_aluop,
   output logic [RADDR-1:0] ex_rd,
   output logic             ex_regwrite,
   output logic             ex_valid,
   output logic [1:0]       fwd_x,
   output logic [1:0]       fwd_y
);

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b10;
   localparam logic [1:0] FWD_MEMWB = 2'b01;

   logic             r_valid;
   logic             r_regwrite;
   logic             r_alusrc;
   logic [OPW-1:0]   r_aluop;
   logic [RADDR-1:0] r_rs;
   logic [RADDR-1:0] r_rt;
   logic [RADDR-1:0] r_rd;
   logic [WIDTH-1:0] r_rs_data;
   logic [WIDTH-1:0] r_rt_data;
   logic [WIDTH-1:0] r_imm;

   logic [1:0]       w_fwd_x;
   logic [1:0]       w_fwd_y;
   logic [WIDTH-1:0] w_x;
   logic [WIDTH-1:0] w_rt;

   // EX/MEM is checked first so the newest in-flight value wins; r0 never
   // forwards because its architectural value is fixed.
   function automatic logic [1:0] fwd_sel(
      input logic [RADDR-1:0] src,
      input logic             exw,
      input logic [RADDR-1:0] exrd,
      input logic             mww,
      input logic [RADDR-1:0] mwrd
   );
      if (exw && (exrd == src) && (src != '0))
         return FWD_EXMEM;
      else if (mww && (mwrd == src) && (src != '0))
         return FWD_MEMWB;
      else
         return FWD_RF;
   endfunction

   function automatic logic [WIDTH-1:0] fwd_mux(
      input logic [1:0]       sel,
      input logic [WIDTH-1:0] rf,
      input logic [WIDTH-1:0] exr,
      input logic [WIDTH-1:0] mwr
   );
      case (sel)
         FWD_EXMEM: return exr;
         FWD_MEMWB: return mwr;
         default:   return rf;
      endcase
   endfunction

   // ---- ID -> EX register boundary ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n || flush) begin
         r_valid    <= 1'b0;
         r_regwrite <= 1'b0;
         r_alusrc   <= 1'b0;
         r_aluop    <= '0;
         r_rs       <= '0;
         r_rt       <= '0;
         r_rd       <= '0;
         r_rs_data  <= '0;
         r_rt_data  <= '0;
         r_imm      <= '0;
      end else if (!stall) begin
         r_valid    <= id_valid;
         r_regwrite <= id_regwrite & id_valid;
         r_alusrc   <= id_alusrc;
         r_aluop    <= id_aluop;
         r_rs       <= id_rs;
         r_rt       <= id_rt;
         r_rd       <= id_rd;
         r_rs_data  <= id_rs_data;
         r_rt_data  <= id_rt_data;
         r_imm      <= id_imm;
      end
   end

   // ---- EX operand resolution (combinational) ----
   // Re-evaluated every cycle, so a held (stalled) instruction still picks up
   // results that arrive on the writeback paths while it waits.
   always_comb begin
      w_fwd_x = fwd_sel(r_rs, exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd);
      w_fwd_y = fwd_sel(r_rt, exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd);
      w_x     = fwd_mux(w_fwd_x, r_rs_data, exmem_result, memwb_result);
      w_rt    = fwd_mux(w_fwd_y, r_rt_data, exmem_result, memwb_result);
   end

   assign NewX         = w_x;
   // fwd_y keeps reporting the rt decision even when the immediate feeds Y,
   // since the forwarded rt value still drives ex_storedata.
   assign NewY         = r_alusrc ? r_imm : w_rt;
   assign ex_storedata = w_rt;
   assign ex_aluop     = r_aluop;
   assign ex_rd        = r_rd;
   assign ex_regwrite  = r_regwrite;
   assign ex_valid     = r_valid;
   assign fwd_x        = w_fwd_x;
   assign fwd_y        = w_fwd_y;

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;

   localparam int W = 16;
   localparam int A = 3;
   localparam int O = 3;

   typedef struct packed {
      logic [W-1:0] newx;
      logic [W-1:0] newy;
      logic [W-1:0] store;
      logic [O-1:0] aluop;
      logic [A-1:0] rd;
      logic         rw;
      logic         valid;
      logic [1:0]   fx;
      logic [1:0]   fy;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         id_valid, id_alusrc, id_regwrite, stall, flush;
   logic [W-1:0] id_rs_data, id_rt_data, id_imm;
   logic [A-1:0] id_rs, id_rt, id_rd;
   logic [O-1:0] id_aluop;
   logic         exmem_regwrite, memwb_regwrite;
   logic [A-1:0] exmem_rd, memwb_rd;
   logic [W-1:0] exmem_result, memwb_result;
   logic [W-1:0] NewX, NewY, ex_storedata;
   logic [O-1:0] ex_aluop;
   logic [A-1:0] ex_rd;
   logic         ex_regwrite, ex_valid;
   logic [1:0]   fwd_x, fwd_y;

   // reference state of the ID/EX register
   logic         m_valid, m_rw, m_alusrc;
   logic [O-1:0] m_aluop;
   logic [A-1:0] m_rs, m_rt, m_rd;
   logic [W-1:0] m_rsd, m_rtd, m_imm;

   exp_t sb[$];
   exp_t e;
   int   checks = 0;
   int   passes = 0;

   alu_operand_stage #(.WIDTH(W), .RADDR(A), .OPW(O)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alusrc(id_alusrc),
      .id_aluop(id_aluop), .id_regwrite(id_regwrite), .stall(stall), .flush(flush),
      .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
      .NewX(NewX), .NewY(NewY), .ex_storedata(ex_storedata), .ex_aluop(ex_aluop),
      .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_valid(ex_valid),
      .fwd_x(fwd_x), .fwd_y(fwd_y)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", passes, checks);
      $fatal(1);
   end

   function automatic exp_t obs();
      return {NewX, NewY, ex_storedata, ex_aluop, ex_rd, ex_regwrite, ex_valid, fwd_x, fwd_y};
   endfunction

   function automatic logic [1:0] ref_sel(input logic [A-1:0] s);
      if (s == 0)                                    return 2'b00;
      if (exmem_regwrite === 1'b1 && exmem_rd === s) return 2'b10;
      if (memwb_regwrite === 1'b1 && memwb_rd === s) return 2'b01;
      return 2'b00;
   endfunction

   function automatic exp_t ref_out();
      exp_t r;
      logic [W-1:0] rtv;
      r.fx    = ref_sel(m_rs);
      r.fy    = ref_sel(m_rt);
      r.newx  = (r.fx == 2'b10) ? exmem_result : (r.fx == 2'b01) ? memwb_result : m_rsd;
      rtv     = (r.fy == 2'b10) ? exmem_result : (r.fy == 2'b01) ? memwb_result : m_rtd;
      r.store = rtv;
      r.newy  = m_alusrc ? m_imm : rtv;
      r.aluop = m_aluop;
      r.rd    = m_rd;
      r.rw    = m_rw;
      r.valid = m_valid;
      return r;
   endfunction

   task automatic model_clear();
      m_valid = 0; m_rw = 0; m_alusrc = 0; m_aluop = 0;
      m_rs = 0; m_rt = 0; m_rd = 0; m_rsd = 0; m_rtd = 0; m_imm = 0;
   endtask

   task automatic set_id(input logic v, input logic [A-1:0] rs, input logic [A-1:0] rt,
                         input logic [A-1:0] rd, input logic [W-1:0] rsd,
                         input logic [W-1:0] rtd, input logic [W-1:0] imm,
                         input logic src, input logic [O-1:0] op, input logic rw);
      id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = rsd;
      id_rt_data = rtd; id_imm = imm; id_alusrc = src; id_aluop = op; id_regwrite = rw;
   endtask

   task automatic set_fwd(input logic exw, input logic [A-1:0] exrd, input logic [W-1:0] exr,
                          input logic mww, input logic [A-1:0] mwrd, input logic [W-1:0] mwr);
      exmem_regwrite = exw; exmem_rd = exrd; exmem_result = exr;
      memwb_regwrite = mww; memwb_rd = mwrd; memwb_result = mwr;
   endtask

   // Advance one clock: update the reference register, queue the expected
   // outputs for the current forwarding inputs, and settle just after the edge.
   task automatic step();
      if (flush) model_clear();
      else if (!stall) begin
         m_valid = id_valid; m_rw = id_regwrite & id_valid; m_alusrc = id_alusrc;
         m_aluop = id_aluop; m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
         m_rsd = id_rs_data; m_rtd = id_rt_data; m_imm = id_imm;
      end
      sb.push_back(ref_out());
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if (obs() !== '0) $display("FAIL reset_state got=%h exp=0", obs());
      else passes++;
      @(negedge clk);
      rst_n = 1'b1;
      set_id(1, 3'd1, 3'd2, 3'd5, 16'hAAAA, 16'h5555, 16'h0001, 0, 3'd4, 1);
      step();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) $display("FAIL reset_preload got=%h exp=%h", obs(), e);
      else passes++;
      #2;
      rst_n = 1'b0;
      model_clear();
      #1;
      checks++;
      if ({ex_valid, ex_regwrite, NewX, NewY} !== '0 || obs() !== '0)
         $display("FAIL async_reset got=%h exp=0", obs());
      else passes++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_plain_load();
      set_fwd(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
      set_id(1, 3'd1, 3'd2, 3'd4, 16'h00F0, 16'h0F0F, 16'h1234, 0, 3'd3, 1);
      step();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) $display("FAIL plain_load got=%h exp=%h", obs(), e);
      else passes++;
      checks++;
      if ({NewX, NewY, fwd_x, fwd_y, ex_valid, ex_regwrite} !== {16'h00F0, 16'h0F0F, 4'b0000, 2'b11})
         $display("FAIL plain_load_const got=%h/%h exp=00f0/0f0f", NewX, NewY);
      else passes++;
   endtask

   task automatic test_immediate();
      set_fwd(1, 3'd3, 16'hBEEF, 0, 3'd0, 16'h0);
      set_id(1, 3'd5, 3'd3, 3'd6, 16'h0101, 16'h0202, 16'hFFFF, 1, 3'd2, 1);
      step();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) $display("FAIL immediate got=%h exp=%h", obs(), e);
      else passes++;
      checks++;
      if ({NewY, fwd_y, ex_storedata} !== {16'hFFFF, 2'b10, 16'hBEEF})
         $display("FAIL immediate_const got=%h/%b/%h exp=ffff/10/beef", NewY, fwd_y, ex_storedata);
      else passes++;
   endtask

   task automatic test_double_hazard();
      set_fwd(1, 3'd2, 16'h1234, 1, 3'd2, 16'h5678);
      set_id(1, 3'd2, 3'd6, 3'd7, 16'h0F00, 16'h00CC, 16'h0000, 0, 3'd1, 1);
      step();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) $display("FAIL double_hazard got=%h exp=%h", obs(), e);
      else passes++;
      checks++;
      if ({NewX, fwd_x} !== {16'h1234, 2'b10})
         $display("FAIL double_hazard_prio got=%h/%b exp=1234/10", NewX, fwd_x);
      else passes++;
      // EX/MEM drops out: MEM/WB takes over within the same cycle
      exmem_regwrite = 0;
      #1;
      sb.push_back(ref_out());
      e = sb.pop_front();
      checks++;
      if (obs() !== e || {NewX, fwd_x} !== {16'h5678, 2'b01})
         $display("FAIL memwb_fallback got=%h exp=%h", obs(), e);
      else passes++;
      // r0 never forwards even when both writebacks target it
      set_fwd(1, 3'd0, 16'h1234, 1, 3'd0, 16'h5678);
      set_id(1, 3'd0, 3'd0, 3'd7, 16'h0042, 16'h0024, 16'h0000, 0, 3'd1, 1);
      step();
      e = sb.pop_front();
      checks++;
      if (obs() !== e || {NewX, fwd_x, fwd_y} !== {16'h0042, 4'b0000})
         $display("FAIL r0_no_forward got=%h exp=%h", obs(), e);
      else passes++;
   endtask

   task automatic test_stall_flush();
      set_fwd(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
      set_id(1, 3'd1, 3'd2, 3'd3, 16'hC0DE, 16'hF00D, 16'h0077, 0, 3'd5, 1);
      step();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) $display("FAIL stall_preload got=%h exp=%h", obs(), e);
      else passes++;
      stall = 1;
      for (int i = 0; i < 2; i++) begin
         set_id(1, 3'd4, 3'd5, 3'd6, 16'h1111 * (i + 1), 16'h2222, 16'h3333, 1, 3'd7, 0);
         step();
         e = sb.pop_front();
         checks++;
         if (obs() !== e || {NewX, NewY, ex_aluop} !== {16'hC0DE, 16'hF00D, 3'd5})
            $display("FAIL stall_hold%0d got=%h exp=%h", i, obs(), e);
         else passes++;
      end
      flush = 1;
      step();
      e = sb.pop_front();
      checks++;
      if (obs() !== e || {ex_valid, ex_regwrite, fwd_x, fwd_y} !== 6'b0)
         $display("FAIL flush_over_stall got=%h exp=%h", obs(), e);
      else passes++;
      stall = 0;
      flush = 0;
   endtask

   task automatic test_memwb_stall();
      set_fwd(0, 3'd0, 16'h0, 0, 3'd1, 16'h0);
      set_id(1, 3'd4, 3'd1, 3'd2, 16'h1111, 16'h2222, 16'h0, 0, 3'd6, 1);
      step();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) $display("FAIL memwb_stall_load got=%h exp=%h", obs(), e);
      else passes++;
      stall = 1;
      step();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) $display("FAIL memwb_stall_hold got=%h exp=%h", obs(), e);
      else passes++;
      set_fwd(0, 3'd0, 16'h0, 1, 3'd4, 16'h00AA);
      #1;
      sb.push_back(ref_out());
      e = sb.pop_front();
      checks++;
      if (obs() !== e || {NewX, fwd_x} !== {16'h00AA, 2'b01})
         $display("FAIL memwb_during_stall got=%h/%b exp=00aa/01", NewX, fwd_x);
      else passes++;
      stall = 0;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 40; i++) begin
         set_id($urandom_range(0, 1), A'($urandom), A'($urandom), A'($urandom),
                W'($urandom), W'($urandom), W'($urandom), $urandom_range(0, 1),
                O'($urandom), $urandom_range(0, 1));
         set_fwd($urandom_range(0, 1), A'($urandom), W'($urandom),
                 $urandom_range(0, 1), A'($urandom), W'($urandom));
         stall = ($urandom_range(0, 4) == 0);
         flush = ($urandom_range(0, 6) == 0);
         step();
         e = sb.pop_front();
         checks++;
         if (obs() !== e) $display("FAIL back_to_back%0d got=%h exp=%h", i, obs(), e);
         else passes++;
      end
      stall = 0;
      flush = 0;
   endtask

   initial begin
      rst_n = 1'b0;
      stall = 0;
      flush = 0;
      set_id(0, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0, 0, 3'd0, 0);
      set_fwd(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
      model_clear();
      test_reset();
      test_plain_load();
      test_immediate();
      test_double_hazard();
      test_stall_flush();
      test_memwb_stall();
      test_back_to_back();
      checks++;
      if (sb.size() != 0) $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
      else passes++;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
